// File: rtl/visor_uart_pkg.sv
// Shared types and default constants for the visor Avalon-MM UART transmitter.
// Default addresses match the visor's console/trace register map.
package visor_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam logic [15:0] VISOR_AV_TX_DATA = 16'h0020;
    localparam logic [15:0] VISOR_AV_TX_CTRL = 16'h0021;

endpackage

// File: rtl/visor_byte_fifo.sv
// Byte FIFO with a separate occupancy counter so that full and empty stay distinguishable.
// dout shows the head entry combinationally whenever the FIFO is not empty.
module visor_byte_fifo #(
    parameter int unsigned  DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == LVL_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = count_q;
    assign dout    = mem[rd_ptr_q];

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Flush only rewinds pointers; stale storage is never visible because count is zero.
    always_ff @(posedge sysclk) begin
        if (sysreset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/visor_av_uart_tx.sv
// Avalon-MM write-only console port for the visor: bytes are queued and sent as 8N1 frames.
// Back-pressure is via av_waitrequest only, raised while a data write targets a full FIFO.
module visor_av_uart_tx
    import visor_uart_pkg::*;
#(
    parameter int unsigned  CLKS_PER_BIT = 434,
    parameter int unsigned  FIFO_DEPTH   = 16,
    parameter logic [15:0]  ADDR_TX_DATA = VISOR_AV_TX_DATA,
    parameter logic [15:0]  ADDR_TX_CTRL = VISOR_AV_TX_CTRL,
    localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic [15:0]      av_address,
    input  logic [15:0]      av_writedata,
    input  logic             av_write,
    output logic             av_waitrequest,
    output logic             uart_txd,
    output logic             tx_busy,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] BIT_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    logic                      data_sel;
    logic                      ctrl_sel;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_flush;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_dout;
    logic                      bit_done;
    logic                      unused_wdata;

    tx_state_t                 state_q, state_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;

    assign data_sel       = (av_address == ADDR_TX_DATA);
    assign ctrl_sel       = (av_address == ADDR_TX_CTRL);
    assign av_waitrequest = av_write && data_sel && fifo_full;
    assign fifo_push      = av_write && data_sel && !fifo_full;
    assign fifo_flush     = av_write && ctrl_sel && av_writedata[0];
    assign fifo_pop       = (state_q == IDLE) && !fifo_empty;
    assign unused_wdata   = ^av_writedata[15:8];

    visor_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .din      (av_writedata[7:0]),
        .dout     (fifo_dout),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bit_done = (timer_q == '0);
    assign uart_txd = txd_q;
    assign tx_busy  = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        // Timer runs down each bit and reloads on the boundary cycle.
        if (state_q != IDLE) begin
            timer_d = bit_done ? BIT_LAST : timer_q - TMR_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    shift_d = fifo_dout;
                    txd_d   = 1'b0;
                    timer_d = BIT_LAST;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_IDX) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_visor_av_uart_tx.sv
// Bench for visor_av_uart_tx: accepted data writes feed a byte scoreboard that is
// compared against frames decoded from uart_txd by a sampling receiver.
module tb_visor_av_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = 5;
    localparam logic [15:0] A_DATA = 16'h0020;
    localparam logic [15:0] A_CTRL = 16'h0021;

    logic             sysclk = 1'b0;
    logic             sysreset = 1'b1;
    logic [15:0]      av_address = '0;
    logic [15:0]      av_writedata = '0;
    logic             av_write = 1'b0;
    logic             av_waitrequest;
    logic             uart_txd;
    logic             tx_busy;
    logic [LVL_W-1:0] fifo_level;

    visor_av_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_TX_DATA (A_DATA),
        .ADDR_TX_CTRL (A_CTRL)
    ) dut (
        .sysclk         (sysclk),
        .sysreset       (sysreset),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_write       (av_write),
        .av_waitrequest (av_waitrequest),
        .uart_txd       (uart_txd),
        .tx_busy        (tx_busy),
        .fifo_level     (fifo_level)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Receiver results; written only by the monitor, read by the main thread.
    logic [7:0] rx_byte  [64];
    logic       rx_ok    [64];
    int         rx_start [64];
    int         frames = 0;
    int         aborts = 0;
    logic       prev_txd = 1'b1;

    // Scoreboard state; touched only by the main thread.
    logic [7:0] sb [$];
    int         rd_idx = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_frame();
        logic       ok;
        logic [7:0] b;
        int         st;
        ok = 1'b1;
        b  = '0;
        st = cyc;
        for (int k = 0; k < CPB - 1; k++) begin
            @(negedge sysclk);
            if (sysreset) begin aborts++; return; end
            if (uart_txd !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge sysclk);
                if (sysreset) begin aborts++; return; end
                if (j == 0) b[i] = uart_txd;
                else if (uart_txd !== b[i]) ok = 1'b0;
            end
        end
        for (int k = 0; k < CPB; k++) begin
            @(negedge sysclk);
            if (sysreset) begin aborts++; return; end
            if (uart_txd !== 1'b1) ok = 1'b0;
        end
        if (frames < 64) begin
            rx_byte[frames]  = b;
            rx_ok[frames]    = ok;
            rx_start[frames] = st;
        end
        frames++;
    endtask

    always begin
        @(negedge sysclk);
        if (!sysreset && prev_txd === 1'b1 && uart_txd === 1'b0) rx_frame();
        prev_txd = uart_txd;
    end

    // Called right after a posedge (+#1); returns stall count and accept cycle.
    task automatic av_wr(input logic [15:0] addr, input logic [15:0] data,
                         output int stalls, output int acc);
        logic done;
        av_address   = addr;
        av_writedata = data;
        av_write     = 1'b1;
        stalls       = 0;
        done         = 1'b0;
        while (!done) begin
            @(negedge sysclk);
            if (!av_waitrequest) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls >= 200) begin
                    check_eq("wr_timeout", 32'(stalls), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge sysclk);
        #1;
        acc = cyc;
        if (addr == A_DATA && stalls < 200) sb.push_back(data[7:0]);
        av_write = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound, output int n);
        n = 0;
        while (tx_busy && n < bound) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        check_eq({tag, "_idle"}, 32'(tx_busy), 32'd0);
        repeat (2) @(posedge sysclk);
        #1;
    endtask

    task automatic compare_frames(input string tag);
        logic [7:0] exp_b;
        while (rd_idx < frames && rd_idx < 64) begin
            check_eq({tag, "_shape"}, 32'(rx_ok[rd_idx]), 32'd1);
            check_eq({tag, "_expected"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check_eq({tag, "_byte"}, 32'(rx_byte[rd_idx]), 32'(exp_b));
            end
            rd_idx++;
        end
        check_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int st, acc, acc0, n, f0, viol, ab0, diff;
        int stalls_first;

        repeat (3) @(posedge sysclk);
        #1;
        sysreset = 1'b0;
        check_eq("rst_txd", 32'(uart_txd), 32'd1);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_waitreq", 32'(av_waitrequest), 32'd0);

        // 1: single byte latency, timing and content
        f0 = frames;
        av_wr(A_DATA, 16'h01A5, st, acc);
        check_eq("t1_stall", 32'(st), 32'd0);
        wait_idle("t1", 200, n);
        check_eq("t1_busy_cycles", 32'(n), 32'd41);
        check_eq("t1_frames", 32'(frames - f0), 32'd1);
        if (frames > f0) check_eq("t1_latency", 32'(rx_start[f0] - acc), 32'd1);
        compare_frames("t1");

        // 2: fill to full, then stall until the second pop
        f0 = frames;
        stalls_first = 0;
        acc0 = 0;
        for (int i = 0; i < 17; i++) begin
            av_wr(A_DATA, 16'(i), st, acc);
            if (i == 0) acc0 = acc;
            stalls_first += st;
        end
        check_eq("t2_no_stall", 32'(stalls_first), 32'd0);
        check_eq("t2_level_full", 32'(fifo_level), 32'd16);
        av_wr(A_DATA, 16'h0011, st, acc);
        check_eq("t2_stall_cycles", 32'(st), 32'd26);
        check_eq("t2_accept_cycle", 32'(acc - acc0), 32'd43);
        check_eq("t2_level_after", 32'(fifo_level), 32'd16);
        wait_idle("t2", 1000, n);
        check_eq("t2_frames", 32'(frames - f0), 32'd18);
        compare_frames("t2");

        // 3: write to an unmapped address is swallowed
        f0 = frames;
        av_wr(16'h0030, 16'h00FF, st, acc);
        check_eq("t3_stall", 32'(st), 32'd0);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (uart_txd !== 1'b1 || fifo_level !== '0 || tx_busy !== 1'b0) viol++;
        end
        check_eq("t3_quiet", 32'(viol), 32'd0);
        check_eq("t3_frames", 32'(frames - f0), 32'd0);
        @(posedge sysclk);
        #1;

        // 4: flush during bit 3 of the first frame
        f0 = frames;
        av_wr(A_DATA, 16'h0011, st, acc);
        av_wr(A_DATA, 16'h0022, st, acc);
        av_wr(A_DATA, 16'h0033, st, acc);
        repeat (16) @(posedge sysclk);
        #1;
        check_eq("t4_level_pre", 32'(fifo_level), 32'd2);
        av_wr(A_CTRL, 16'h0001, st, acc);
        check_eq("t4_level_flushed", 32'(fifo_level), 32'd0);
        void'(sb.pop_back());
        void'(sb.pop_back());
        wait_idle("t4", 200, n);
        check_eq("t4_frames", 32'(frames - f0), 32'd1);
        compare_frames("t4");

        // 5: reset in the middle of DATA with bytes queued
        f0 = frames;
        ab0 = aborts;
        for (int i = 0; i < 5; i++) av_wr(A_DATA, 16'(8'hC0 + i), st, acc);
        repeat (6) @(posedge sysclk);
        #1;
        sysreset = 1'b1;
        @(posedge sysclk);
        #1;
        sysreset = 1'b0;
        sb.delete();
        check_eq("t5_txd", 32'(uart_txd), 32'd1);
        check_eq("t5_level", 32'(fifo_level), 32'd0);
        check_eq("t5_busy", 32'(tx_busy), 32'd0);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            if (uart_txd !== 1'b1) viol++;
        end
        check_eq("t5_quiet", 32'(viol), 32'd0);
        check_eq("t5_aborted", 32'(aborts - ab0), 32'd1);
        check_eq("t5_no_frame", 32'(frames - f0), 32'd0);
        @(posedge sysclk);
        #1;
        av_wr(A_DATA, 16'h003C, st, acc);
        wait_idle("t5", 200, n);
        check_eq("t5_fresh_frames", 32'(frames - f0), 32'd1);
        compare_frames("t5");

        // 6: back-to-back spacing, with a bit0=0 control write in between
        f0 = frames;
        av_wr(A_DATA, 16'h0055, st, acc);
        av_wr(A_CTRL, 16'h0000, st, acc);
        av_wr(A_DATA, 16'h00AA, st, acc);
        wait_idle("t6", 300, n);
        check_eq("t6_frames", 32'(frames - f0), 32'd2);
        diff = (frames - f0 >= 2) ? rx_start[f0 + 1] - rx_start[f0] : -1;
        check_eq("t6_spacing", 32'(diff), 32'd41);
        compare_frames("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/visor_av_uart_tx.md
Name: visor_av_uart_tx

Overview:
Avalon-MM write-only slave placed directly downstream of the visor's Avalon MM master (av_address/av_writedata/av_write/av_waitrequest). Byte writes from the supervisor program are buffered in a small FIFO and serialized out as 8N1 UART frames on a single TX pin. This gives the visor a console/trace channel for reporting breakpoints, peeked data and EXR shadow values. Back-pressure to the visor uses av_waitrequest only.

Parameters:
CLKS_PER_BIT, 434, sysclk cycles per UART bit (50 MHz / 115200); legal range >= 2.
FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.
ADDR_TX_DATA, 16'h0020, Avalon address of the TX data port.
ADDR_TX_CTRL, 16'h0021, Avalon address of the control port.

Ports:
sysclk  in  1  sole clock.
sysreset  in  1  synchronous, active-high reset.
av_address  in  16  Avalon address from the visor.
av_writedata  in  16  Avalon write data; only bits [7:0] are used.
av_write  in  1  Avalon write strobe.
av_waitrequest  out  1  stall; combinational.
uart_txd  out  1  serial output; idle high; registered.
tx_busy  out  1  high whenever state != IDLE or the FIFO is non-empty.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- One clock (sysclk). Reset is synchronous and active-high (sysreset).
- Reset values: uart_txd=1, tx_busy=0, fifo_level=0, av_waitrequest=0, state=IDLE, FIFO pointers=0.
- Reset mid-frame: the frame is aborted, uart_txd=1 from the next edge, and the FIFO is emptied.
- Transfer rule: a write completes on an edge where av_write=1 and av_waitrequest=0. The master holds its address and data while stalled.
- av_waitrequest = av_write && av_address==ADDR_TX_DATA && fifo_level==FIFO_DEPTH.
  - It is never asserted for any other address.
  - A pop on the same cycle does not release the stall; the push completes on the following cycle.
- Write to ADDR_TX_DATA: push av_writedata[7:0]. Bits [15:8] are ignored.
- Write to ADDR_TX_CTRL with bit0=1: flush the FIFO (level=0 next edge).
  - A frame already in progress completes unaltered.
  - bit0=0 is a no-op.
- Writes to any other address: accepted in one cycle and discarded.
- Simultaneous push and pop when not full: occupancy is unchanged and data order is preserved.
- TX FSM states:
  - IDLE: txd=1. If the FIFO is non-empty, pop, load the shift register, set txd<=0, and go to START.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7; after bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Latency: txd falls on the edge after the edge that accepted a write into an empty FIFO with the FSM in IDLE.
- Back-to-back frames: each frame lasts 10*CLKS_PER_BIT cycles, plus one mandatory IDLE cycle. Start-to-start spacing is 10*CLKS_PER_BIT+1 cycles.
- Bit-timer counter: width $clog2(CLKS_PER_BIT). It reloads at each bit boundary and never wraps mid-bit.
- FIFO pointers: width $clog2(FIFO_DEPTH), wrapping naturally. Occupancy is held in a separate counter so the full and empty states are distinguishable.

Decomposition:
- Package visor_uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Constant UART_DATA_BITS=8.
  - Default address constants VISOR_AV_TX_DATA=16'h0020 and VISOR_AV_TX_CTRL=16'h0021.
- One sub-module, visor_byte_fifo (parameter DEPTH). Ports: push, pop, flush, din[7:0], dout[7:0], level, full, empty. dout is valid combinationally while not empty.
- The top-level module holds the address decode, waitrequest, FSM and bit timer.

Test Plan:
(bench parameters: CLKS_PER_BIT=4, FIFO_DEPTH=16)
1. Single byte: write 16'h01A5 to 16'h0020 into an empty FIFO -> waitrequest=0. txd low 1 cycle after accept for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles. tx_busy drops after 41 cycles.
2. Full stall: 18 consecutive writes 0x00..0x11 -> writes 1..17 complete with no stall (byte 0 popped at once, level reaches 16). Write 18 sees waitrequest=1 until byte 0x01 is popped, 41 cycles after byte 0x00 started, then completes. Output order is 0x00..0x11 with no loss.
3. Non-target address: write 16'h00FF to 16'h0030 -> completes in 1 cycle, waitrequest never high, txd stays 1, level stays 0.
4. Flush mid-frame: queue 0x11, 0x22, 0x33. During bit 3 of 0x11, write 16'h0001 to 16'h0021 -> 0x11 completes intact, level=0 the next cycle, no further frames.
5. Reset mid-frame: pulse sysreset for 1 cycle during DATA with 5 bytes queued -> txd=1, level=0, tx_busy=0 after the edge, no frame for 100 cycles. A fresh write afterwards transmits normally.
6. Back-to-back spacing: queue 0x55 and 0xAA -> start edges of the two frames are exactly 41 cycles apart.
